// File: rtl/memory_access_unit_pkg.sv
// Shared types and constants for the memory access unit: funct3 codes, FSM states,
// and the access legality check applied to each incoming request.
package memory_access_unit_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_MERGE = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Stores have no unsigned variants, so any funct3 with bit 2 set is illegal for them.
    function automatic logic access_fault(input logic       is_write,
                                          input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
        logic f;
        f = 1'b0;
        case (funct3)
            F3_B, F3_BU:  f = 1'b0;
            F3_H, F3_HU:  f = addr_lo[0];
            F3_W:         f = (addr_lo != 2'b00);
            default:      f = 1'b1;
        endcase
        if (is_write && funct3[2])
            f = 1'b1;
        return f;
    endfunction

endpackage

// File: rtl/memory_access_unit_lane_merge.sv
// Byte/half lane handling: builds the merged word for SB/SH read-modify-write
// and extracts the sign- or zero-extended lane for loads (little-endian).
module memory_access_unit_lane_merge (
    input  logic [31:0] old_word_i,
    input  logic [31:0] new_data_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] merged_o,
    output logic [31:0] load_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        merged_o = old_word_i;
        case (size_i)
            2'b00: begin
                case (addr_lo_i)
                    2'd0:    merged_o[7:0]   = new_data_i[7:0];
                    2'd1:    merged_o[15:8]  = new_data_i[7:0];
                    2'd2:    merged_o[23:16] = new_data_i[7:0];
                    default: merged_o[31:24] = new_data_i[7:0];
                endcase
            end
            2'b01: begin
                if (addr_lo_i[1])
                    merged_o[31:16] = new_data_i[15:0];
                else
                    merged_o[15:0]  = new_data_i[15:0];
            end
            default: merged_o = new_data_i;
        endcase
    end

    always_comb begin
        case (addr_lo_i)
            2'd0:    byte_lane = old_word_i[7:0];
            2'd1:    byte_lane = old_word_i[15:8];
            2'd2:    byte_lane = old_word_i[23:16];
            default: byte_lane = old_word_i[31:24];
        endcase
        half_lane = addr_lo_i[1] ? old_word_i[31:16] : old_word_i[15:0];

        case (size_i)
            2'b00:   load_o = {{24{byte_lane[7] & ~unsigned_i}}, byte_lane};
            2'b01:   load_o = {{16{half_lane[15] & ~unsigned_i}}, half_lane};
            default: load_o = old_word_i;
        endcase
    end

endmodule

// File: rtl/memory_access_unit.sv
// RV32I load/store front end for a word-wide block memory with 1-cycle registered read.
// state | meaning
// IDLE  | ready for a request
// READ  | read enable issued for latched word address (loads, SB/SH)
// MERGE | read data valid: extract load lane or write merged SB/SH word
// WRITE | SW: write latched store data
// DONE  | response held until resp_ready
module memory_access_unit
    import memory_access_unit_pkg::*;
#(
    parameter int ADDRESS_SIZE = 10
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [2:0]              req_funct3,
    input  logic [31:0]             req_address,
    input  logic [31:0]             req_write_data,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [31:0]             resp_data,
    output logic                    resp_fault,
    output logic                    mem_read_enable,
    output logic                    mem_write_enable,
    output logic [ADDRESS_SIZE-1:0] mem_read_address,
    output logic [ADDRESS_SIZE-1:0] mem_write_address,
    output logic [31:0]             mem_write_data,
    input  logic [31:0]             mem_read_data
);

    state_t                  state_q;
    logic                    write_q;
    logic [2:0]              funct3_q;
    logic [1:0]              addr_lo_q;
    logic [ADDRESS_SIZE-1:0] word_addr_q;
    logic [31:0]             wdata_q;
    logic [31:0]             resp_data_q;
    logic                    resp_fault_q;

    logic                    fault_d;
    logic [31:0]             merged_word;
    logic [31:0]             load_word;
    logic                    unused_addr_bits;

    assign fault_d          = access_fault(req_write, req_funct3, req_address[1:0]);
    assign unused_addr_bits = ^req_address[31:ADDRESS_SIZE+2];

    memory_access_unit_lane_merge u_lane_merge (
        .old_word_i (mem_read_data),
        .new_data_i (wdata_q),
        .addr_lo_i  (addr_lo_q),
        .size_i     (funct3_q[1:0]),
        .unsigned_i (funct3_q[2]),
        .merged_o   (merged_word),
        .load_o     (load_word)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            write_q      <= 1'b0;
            funct3_q     <= 3'b000;
            addr_lo_q    <= 2'b00;
            word_addr_q  <= '0;
            wdata_q      <= 32'h0;
            resp_data_q  <= 32'h0;
            resp_fault_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        write_q      <= req_write;
                        funct3_q     <= req_funct3;
                        addr_lo_q    <= req_address[1:0];
                        word_addr_q  <= req_address[ADDRESS_SIZE+1:2];
                        wdata_q      <= req_write_data;
                        resp_data_q  <= 32'h0;
                        resp_fault_q <= fault_d;
                        if (fault_d)
                            state_q <= ST_DONE;
                        else if (req_write && (req_funct3 == F3_W))
                            state_q <= ST_WRITE;
                        else
                            state_q <= ST_READ;
                    end
                end
                ST_READ:  state_q <= ST_MERGE;
                ST_MERGE: begin
                    if (!write_q)
                        resp_data_q <= load_word;
                    state_q <= ST_DONE;
                end
                ST_WRITE: state_q <= ST_DONE;
                ST_DONE: begin
                    if (resp_ready) begin
                        resp_data_q  <= 32'h0;
                        resp_fault_q <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_DONE);
    assign resp_data  = resp_data_q;
    assign resp_fault = resp_fault_q;

    // Gated by reset_n so a reset edge landing mid-RMW never commits the write.
    assign mem_read_enable   = reset_n && (state_q == ST_READ);
    assign mem_write_enable  = reset_n && ((state_q == ST_WRITE) ||
                                           ((state_q == ST_MERGE) && write_q));
    assign mem_read_address  = word_addr_q;
    assign mem_write_address = word_addr_q;
    assign mem_write_data    = (state_q == ST_WRITE) ? wdata_q : merged_word;

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed self-checking bench for memory_access_unit with a behavioural block memory.
module tb_memory_access_unit;

    localparam int AS = 10;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [2:0]    req_funct3;
    logic [31:0]   req_address;
    logic [31:0]   req_write_data;
    logic          resp_valid;
    logic          resp_ready;
    logic [31:0]   resp_data;
    logic          resp_fault;
    logic          mem_read_enable;
    logic          mem_write_enable;
    logic [AS-1:0] mem_read_address;
    logic [AS-1:0] mem_write_address;
    logic [31:0]   mem_write_data;
    logic [31:0]   mem_read_data;

    logic [31:0]   mem [0:(1<<AS)-1];
    int            rd_cnt = 0;
    int            wr_cnt = 0;
    logic          both_high = 1'b0;

    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    memory_access_unit #(.ADDRESS_SIZE(AS)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_write         (req_write),
        .req_funct3        (req_funct3),
        .req_address       (req_address),
        .req_write_data    (req_write_data),
        .resp_valid        (resp_valid),
        .resp_ready        (resp_ready),
        .resp_data         (resp_data),
        .resp_fault        (resp_fault),
        .mem_read_enable   (mem_read_enable),
        .mem_write_enable  (mem_write_enable),
        .mem_read_address  (mem_read_address),
        .mem_write_address (mem_write_address),
        .mem_write_data    (mem_write_data),
        .mem_read_data     (mem_read_data)
    );

    always @(posedge clk) begin
        if (mem_write_enable) begin
            mem[mem_write_address] <= mem_write_data;
            wr_cnt <= wr_cnt + 1;
        end
        if (mem_read_enable) begin
            mem_read_data <= mem[mem_read_address];
            rd_cnt <= rd_cnt + 1;
        end
        if (mem_read_enable && mem_write_enable)
            both_high <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request, wait for the response, acknowledge it.
    task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output int lat,
                          output logic [31:0] d, output logic flt);
        @(negedge clk);
        req_valid      = 1'b1;
        req_write      = w;
        req_funct3     = f3;
        req_address    = a;
        req_write_data = wd;
        check("req_ready_before_accept", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        d   = resp_data;
        flt = resp_fault;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    int          lat;
    logic [31:0] d;
    logic        f;
    int          rd0, wr0;
    logic [31:0] held;

    initial begin
        reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000;
        req_address = 32'h0; req_write_data = 32'h0; resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req_ready",  {31'b0, req_ready},  32'd1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_resp_data",  resp_data,           32'h0);
        check("rst_resp_fault", {31'b0, resp_fault}, 32'd0);
        check("rst_enables",    {30'b0, mem_read_enable, mem_write_enable}, 32'd0);
        reset_n = 1'b1;

        do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, lat, d, f);
        check("sw_latency", lat, 32'd2);
        check("sw_data",    d,   32'h0);
        check("sw_fault",   {31'b0, f}, 32'd0);
        check("sw_mem",     mem[4], 32'hDEADBEEF);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, lat, d, f);
        check("lw_latency", lat, 32'd3);
        check("lw_data",    d,   32'hDEADBEEF);

        do_req(1'b1, 3'b010, 32'h20, 32'h11223344, lat, d, f);
        do_req(1'b1, 3'b000, 32'h22, 32'h123456AA, lat, d, f);
        check("sb_latency", lat, 32'd3);
        check("sb_fault",   {31'b0, f}, 32'd0);
        do_req(1'b0, 3'b010, 32'h20, 32'h0, lat, d, f);
        check("sb_lw",  d, 32'h11AA3344);
        do_req(1'b0, 3'b000, 32'h22, 32'h0, lat, d, f);
        check("lb_neg", d, 32'hFFFFFFAA);
        do_req(1'b0, 3'b100, 32'h22, 32'h0, lat, d, f);
        check("lbu",    d, 32'h000000AA);
        do_req(1'b0, 3'b000, 32'h21, 32'h0, lat, d, f);
        check("lb_pos", d, 32'h00000033);

        do_req(1'b1, 3'b010, 32'h24, 32'h0, lat, d, f);
        do_req(1'b1, 3'b001, 32'h26, 32'hFFFF8001, lat, d, f);
        check("sh_latency", lat, 32'd3);
        do_req(1'b0, 3'b010, 32'h24, 32'h0, lat, d, f);
        check("sh_lw", d, 32'h80010000);
        do_req(1'b0, 3'b001, 32'h26, 32'h0, lat, d, f);
        check("lh_neg", d, 32'hFFFF8001);
        do_req(1'b0, 3'b101, 32'h26, 32'h0, lat, d, f);
        check("lhu", d, 32'h00008001);
        do_req(1'b0, 3'b001, 32'h20, 32'h0, lat, d, f);
        check("lh_low", d, 32'h00003344);

        rd0 = rd_cnt; wr0 = wr_cnt;
        do_req(1'b0, 3'b010, 32'h13, 32'h0, lat, d, f);
        check("lw_mis_fault", {31'b0, f}, 32'd1);
        check("lw_mis_data",  d,   32'h0);
        check("lw_mis_lat",   lat, 32'd1);
        do_req(1'b0, 3'b001, 32'h21, 32'h0, lat, d, f);
        check("lh_mis_fault", {31'b0, f}, 32'd1);
        check("lh_mis_lat",   lat, 32'd1);
        do_req(1'b0, 3'b011, 32'h0, 32'h0, lat, d, f);
        check("f3_011_fault", {31'b0, f}, 32'd1);
        check("f3_011_data",  d, 32'h0);
        do_req(1'b1, 3'b100, 32'h10, 32'h0, lat, d, f);
        check("st_1xx_fault", {31'b0, f}, 32'd1);
        check("fault_no_rd", rd_cnt, rd0);
        check("fault_no_wr", wr_cnt, wr0);
        check("st_1xx_mem",  mem[4], 32'hDEADBEEF);

        // Response held under back-pressure; competing request must be ignored.
        wr0 = wr_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b000; req_address = 32'h20;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("stall_lat", lat, 32'd3);
        held = resp_data;
        check("stall_data", held, 32'h00000044);
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
            req_address = 32'h40; req_write_data = 32'h5555AAAA;
            @(negedge clk);
            check("stall_valid", {31'b0, resp_valid}, 32'd1);
            check("stall_hold",  resp_data, held);
            check("stall_ready", {31'b0, req_ready}, 32'd0);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("stall_release_ready", {31'b0, req_ready}, 32'd1);
        check("stall_no_write", wr_cnt, wr0);

        // Reset arriving while an SB sits in MERGE.
        do_req(1'b1, 3'b010, 32'h30, 32'hCAFEF00D, lat, d, f);
        wr0 = wr_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000;
        req_address = 32'h30; req_write_data = 32'h00000055;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("merge_wen_live", {31'b0, mem_write_enable}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("merge_wen_gated", {31'b0, mem_write_enable}, 32'd0);
        @(negedge clk);
        check("mrst_req_ready",  {31'b0, req_ready},  32'd1);
        check("mrst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("mrst_resp_data",  resp_data, 32'h0);
        check("mrst_resp_fault", {31'b0, resp_fault}, 32'd0);
        check("mrst_mem",        mem[12], 32'hCAFEF00D);
        check("mrst_no_write",   wr_cnt, wr0);
        reset_n = 1'b1;
        do_req(1'b0, 3'b010, 32'h30, 32'h0, lat, d, f);
        check("mrst_lw", d, 32'hCAFEF00D);

        // Upper address bits alias onto the same word.
        do_req(1'b0, 3'b010, 32'hFFFF_F010, 32'h0, lat, d, f);
        check("alias_lw", d, 32'hDEADBEEF);

        check("enables_exclusive", {31'b0, both_high}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule
